// File: rtl/execute_stage_pipe.sv
// Execute stage: decode, ALU operand/branch steering, multdiv sequencing and X/M register.
// Optional macro MD_TIMEOUT_EN adds a multdiv timeout after MD_MAX_CYCLES cycles.
module execute_stage_pipe #(
    parameter int DATA_W        = 32,
    parameter int MD_MAX_CYCLES = 40
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [31:0]       in_insn,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_dataA,
    input  logic [DATA_W-1:0] in_dataB,
    output logic [4:0]        alu_opcode,
    output logic [4:0]        alu_shamt,
    output logic [DATA_W-1:0] alu_opA,
    output logic [DATA_W-1:0] alu_opB,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ne,
    input  logic              alu_lt,
    output logic              md_start_mult,
    output logic              md_start_div,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_ready,
    input  logic              md_exception,
    output logic              stall,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              out_valid,
    output logic              out_exc,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd
);
    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] FN_MULT  = 5'b00110;
    localparam logic [4:0] FN_DIV   = 5'b00111;
    localparam logic [DATA_W-1:0] ONE_W = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [4:0]        op_s, fn_s, rd_s, wb_rd_s;
    logic [DATA_W-1:0] imm_s, jtgt_s, pc_inc_s, wb_res_s;
    logic              is_mult_s, is_div_s, br_cond_s;
    logic              stall_s, start_mult_s, start_div_s;
    logic              load_sc_s, load_md_s, load_to_s, timeout_s;
    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d, out_exc_q, out_exc_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [4:0]        out_rd_q, out_rd_d;

    assign op_s     = in_insn[31:27];
    assign fn_s     = in_insn[6:2];
    assign rd_s     = in_insn[26:22];
    assign imm_s    = {{(DATA_W-17){in_insn[16]}}, in_insn[16:0]};
    assign jtgt_s   = {{(DATA_W-27){1'b0}}, in_insn[26:0]};
    assign pc_inc_s = in_pc + ONE_W;

    // Instruction decode: ALU steering, writeback fields and branch condition/target.
    always_comb begin
        alu_opcode    = 5'd0;
        alu_shamt     = 5'd0;
        alu_opA       = in_dataA;
        alu_opB       = in_dataB;
        wb_rd_s       = rd_s;
        wb_res_s      = alu_result;
        is_mult_s     = 1'b0;
        is_div_s      = 1'b0;
        br_cond_s     = 1'b0;
        branch_target = pc_inc_s + imm_s;
        case (op_s)
            OP_RTYPE: begin
                alu_opcode = fn_s;
                alu_shamt  = in_insn[11:7];
                is_mult_s  = (fn_s == FN_MULT);
                is_div_s   = (fn_s == FN_DIV);
            end
            OP_ADDI, OP_LW: alu_opB = imm_s;
            OP_SW: begin
                alu_opB = imm_s;
                wb_rd_s = 5'd0;
            end
            OP_BNE: begin
                alu_opcode = 5'b00001;
                wb_rd_s    = 5'd0;
                br_cond_s  = alu_ne;
            end
            OP_BLT: begin
                alu_opcode = 5'b00001;
                wb_rd_s    = 5'd0;
                br_cond_s  = alu_lt;
            end
            OP_J: begin
                wb_rd_s       = 5'd0;
                br_cond_s     = 1'b1;
                branch_target = jtgt_s;
            end
            OP_JAL: begin
                alu_opA       = in_pc;
                alu_opB       = {DATA_W{1'b0}};
                wb_rd_s       = 5'd31;
                wb_res_s      = pc_inc_s;
                br_cond_s     = 1'b1;
                branch_target = jtgt_s;
            end
            OP_JR: begin
                wb_rd_s       = 5'd0;
                br_cond_s     = 1'b1;
                branch_target = in_dataA;
            end
            default: begin
                alu_opcode = 5'd0;
            end
        endcase
    end

`ifdef MD_TIMEOUT_EN
    localparam int CNT_W = $clog2(MD_MAX_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_s = (state_q == BUSY) && (cnt_q == CNT_W'(MD_MAX_CYCLES - 1));

    // Cycle counter: cleared on issue, advances while waiting in BUSY.
    always_comb begin
        if (state_q == IDLE) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] md_max_unused_s;
    assign md_max_unused_s = 32'(MD_MAX_CYCLES);
    assign timeout_s       = 1'b0;
`endif

    // Multdiv sequencer: issue pulse in IDLE, wait in BUSY for ready (or timeout).
    always_comb begin
        state_d      = state_q;
        stall_s      = 1'b0;
        start_mult_s = 1'b0;
        start_div_s  = 1'b0;
        load_sc_s    = 1'b0;
        load_md_s    = 1'b0;
        load_to_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && (is_mult_s || is_div_s)) begin
                    stall_s      = 1'b1;
                    start_mult_s = is_mult_s;
                    start_div_s  = is_div_s;
                    state_d      = BUSY;
                end else begin
                    load_sc_s = 1'b1;
                end
            end
            BUSY: begin
                if (md_ready) begin
                    load_md_s = 1'b1;
                    state_d   = IDLE;
                end else if (timeout_s) begin
                    load_to_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held.
    assign stall         = stall_s & reset_n;
    assign md_start_mult = start_mult_s & reset_n;
    assign md_start_div  = start_div_s & reset_n;
    assign branch_taken  = in_valid & ~stall & br_cond_s;

    // X/M next-state: multdiv result, timeout fault, single-cycle result or hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_exc_d    = out_exc_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        if (load_md_s) begin
            out_valid_d  = 1'b1;
            out_exc_d    = md_exception;
            out_result_d = md_result;
            out_rd_d     = rd_s;
        end else if (load_to_s) begin
            out_valid_d  = 1'b1;
            out_exc_d    = 1'b1;
            out_result_d = {DATA_W{1'b0}};
            out_rd_d     = rd_s;
        end else if (load_sc_s) begin
            out_valid_d  = in_valid;
            out_exc_d    = 1'b0;
            out_result_d = wb_res_s;
            out_rd_d     = wb_rd_s;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // State and X/M registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_exc_q    <= 1'b0;
            out_result_q <= {DATA_W{1'b0}};
            out_rd_q     <= 5'd0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_exc_q    <= out_exc_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_exc    = out_exc_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
endmodule

// File: tb/tb_execute_stage_pipe.sv
// Self-checking bench for execute_stage_pipe: directed cases plus randomized
// single-cycle traffic and multdiv sequences against a behavioural model.
module tb_execute_stage_pipe;
    localparam int MDMAX = 40;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_insn = 32'd0, in_pc = 32'd0, in_dataA = 32'd0, in_dataB = 32'd0;
    logic [4:0]  alu_opcode, alu_shamt, out_rd;
    logic [31:0] alu_opA, alu_opB, branch_target, out_result;
    logic [31:0] alu_result = 32'd0, md_result = 32'd0;
    logic        alu_ne = 1'b0, alu_lt = 1'b0, md_ready = 1'b0, md_exception = 1'b0;
    logic        md_start_mult, md_start_div, stall, branch_taken, out_valid, out_exc;

    int checks = 0;
    int errors = 0;

    execute_stage_pipe #(.DATA_W(32), .MD_MAX_CYCLES(MDMAX)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_insn(in_insn),
        .in_pc(in_pc), .in_dataA(in_dataA), .in_dataB(in_dataB),
        .alu_opcode(alu_opcode), .alu_shamt(alu_shamt), .alu_opA(alu_opA), .alu_opB(alu_opB),
        .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt),
        .md_start_mult(md_start_mult), .md_start_div(md_start_div),
        .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .out_valid(out_valid), .out_exc(out_exc), .out_result(out_result), .out_rd(out_rd)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        chk_op;
        logic [4:0]  opc;
        logic        chk_sh;
        logic [4:0]  shamt;
        logic        chk_ab;
        logic [31:0] opa;
        logic [31:0] opb;
        logic        tkn;
        logic [31:0] tgt;
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    // Reference: instruction semantics expressed with plain integer arithmetic.
    function automatic exp_t model(input logic [31:0] insn, pc, a, b, alu,
                                   input logic ne, lt, vld);
        exp_t e;
        int unsigned op, imm_u, jt;
        int imm;
        op    = insn >> 27;
        imm_u = insn & 32'h0001FFFF;
        imm   = (imm_u >= 65536) ? int'(imm_u) - 131072 : int'(imm_u);
        jt    = insn & 32'h07FFFFFF;
        e        = '0;
        e.rd     = 5'((insn >> 22) % 32);
        e.res    = alu;
        e.opa    = a;
        e.opb    = b;
        e.chk_ab = 1'b1;
        e.tgt    = 32'(pc + 32'd1 + 32'(imm));
        case (op)
            0: begin
                e.chk_op = 1'b1; e.opc = 5'((insn >> 2) % 32);
                e.chk_sh = 1'b1; e.shamt = 5'((insn >> 7) % 32);
            end
            5, 7, 8: begin
                e.chk_op = 1'b1; e.chk_sh = 1'b1; e.opb = 32'(imm);
                if (op == 7) e.rd = 5'd0;
            end
            2, 6: begin
                e.chk_op = 1'b1; e.opc = 5'd1; e.rd = 5'd0;
                e.tkn = vld & ((op == 2) ? ne : lt);
            end
            1: begin e.chk_ab = 1'b0; e.rd = 5'd0; e.tkn = vld; e.tgt = jt; end
            3: begin
                e.opa = pc; e.opb = 32'd0; e.rd = 5'd31; e.res = pc + 32'd1;
                e.tkn = vld; e.tgt = jt;
            end
            4: begin e.chk_ab = 1'b0; e.rd = 5'd0; e.tkn = vld; e.tgt = a; end
            default: e.chk_ab = 1'b0;
        endcase
        return e;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({out_valid, out_exc, out_result, out_rd, stall, md_start_mult, md_start_div} !== 41'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b e=%b r=%h rd=%0d st=%b, want all zero",
                     out_valid, out_exc, out_result, out_rd, stall);
        end
        reset_n = 1'b1;
    endtask

    // Applies one single-cycle instruction, checks combinational then registered outputs.
    task automatic apply_sc(input string name, input logic vld, input logic [31:0] insn, pc,
                            a, b, alu, input logic ne, lt);
        exp_t e;
        in_valid = vld; in_insn = insn; in_pc = pc; in_dataA = a; in_dataB = b;
        alu_result = alu; alu_ne = ne; alu_lt = lt;
        e = model(insn, pc, a, b, alu, ne, lt, vld);
        #1;
        checks++;
        if ({branch_taken, branch_target, stall, md_start_mult, md_start_div} !== {e.tkn, e.tgt, 3'b000}) begin
            errors++;
            $display("FAIL %s_branch: got tkn=%b tgt=%0d st=%b, want tkn=%b tgt=%0d st=0",
                     name, branch_taken, branch_target, stall, e.tkn, e.tgt);
        end
        checks++;
        if ((e.chk_op && alu_opcode !== e.opc) || (e.chk_sh && alu_shamt !== e.shamt) ||
            (e.chk_ab && {alu_opA, alu_opB} !== {e.opa, e.opb})) begin
            errors++;
            $display("FAIL %s_alu: got op=%0d sh=%0d A=%h B=%h, want op=%0d sh=%0d A=%h B=%h",
                     name, alu_opcode, alu_shamt, alu_opA, alu_opB, e.opc, e.shamt, e.opa, e.opb);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({out_valid, out_exc} !== {vld, 1'b0} || out_result !== e.res || out_rd !== e.rd) begin
            errors++;
            $display("FAIL %s_xm: got v=%b e=%b r=%h rd=%0d, want v=%b e=0 r=%h rd=%0d",
                     name, out_valid, out_exc, out_result, out_rd, vld, e.res, e.rd);
        end
    endtask

    task automatic test_directed();
        apply_sc("add", 1'b1, {5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 2'b00}, 32'd10, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        apply_sc("bne_taken", 1'b1, {5'b00010, 5'd0, 5'd0, 17'h1FFFC}, 32'd100, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
        apply_sc("bne_not", 1'b1, {5'b00010, 5'd0, 5'd0, 17'h1FFFC}, 32'd100, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
        apply_sc("jal", 1'b1, {5'b00011, 27'h123}, 32'd50, 32'd9, 32'd9, 32'hDEAD, 1'b0, 1'b0);
        apply_sc("idle", 1'b0, {5'b00001, 27'h55}, 32'd7, 32'd0, 32'd0, 32'd5, 1'b0, 1'b0);
    endtask

    task automatic test_random_single();
        logic [4:0]  ops [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
        logic [31:0] r, insn;
        for (int i = 0; i < 60; i++) begin
            r    = $urandom();
            insn = {ops[$urandom_range(0, 8)], r[26:0]};
            if (insn[31:27] == 5'd0 && (insn[6:2] == 5'd6 || insn[6:2] == 5'd7)) insn[5] = 1'b1;
            apply_sc("rand", ($urandom_range(0, 4) != 0), insn, $urandom(), $urandom(),
                     $urandom(), $urandom(), 1'($urandom()), 1'($urandom()));
        end
        in_valid = 1'b0;
    endtask

    // Issues mult/div; ready arrives so that stall is high for exactly lat cycles.
    task automatic run_md(input string name, input logic is_div, input int lat,
                          input logic [31:0] res, input logic exc);
        logic [31:0] r, hold_res;
        logic        hold_v;
        int          st;
        r = $urandom();
        hold_res = out_result; hold_v = out_valid;
        in_valid = 1'b1; in_insn = {5'd0, r[26:7], (is_div ? 5'd7 : 5'd6), 2'b00};
        md_ready = 1'b0; md_result = $urandom();
        #1;
        checks++;
        if ({md_start_mult, md_start_div, stall, branch_taken} !== {~is_div, is_div, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s_issue: got m=%b d=%b st=%b, want m=%b d=%b st=1",
                     name, md_start_mult, md_start_div, stall, ~is_div, is_div);
        end
        st = 1;
        @(posedge clock);
        #1;
        checks++;
        if ({out_valid, out_result} !== {hold_v, hold_res}) begin
            errors++;
            $display("FAIL %s_hold: got v=%b r=%h, want v=%b r=%h", name, out_valid, out_result, hold_v, hold_res);
        end
        for (int i = 1; i < lat; i++) begin
            if (stall === 1'b1 && md_start_mult === 1'b0 && md_start_div === 1'b0) st++;
            @(posedge clock);
            #1;
        end
        checks++;
        if (st !== lat) begin
            errors++;
            $display("FAIL %s_stall_cycles: got %0d, want %0d", name, st, lat);
        end
        md_ready = 1'b1; md_result = res; md_exception = exc;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got stall=%b, want 0", name, stall);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({out_valid, out_exc, out_result, out_rd} !== {1'b1, exc, res, r[26:22]}) begin
            errors++;
            $display("FAIL %s_result: got v=%b e=%b r=%0d rd=%0d, want v=1 e=%b r=%0d rd=%0d",
                     name, out_valid, out_exc, out_result, out_rd, exc, res, r[26:22]);
        end
        md_ready = 1'b0; md_exception = 1'b0;
    endtask

    task automatic test_multdiv();
        run_md("mult17", 1'b0, 17, 32'd42, 1'b0);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            run_md("md_rand", 1'($urandom()), $urandom_range(1, 30), $urandom(), 1'($urandom()));
            in_valid = 1'b0;
            md_ready = 1'b1;
            @(posedge clock);
            #1;
            checks++;
            if ({out_valid, stall} !== 2'b00) begin
                errors++;
                $display("FAIL stray_ready_idle: got v=%b st=%b, want 0 0", out_valid, stall);
            end
            md_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        run_md("b2b_mult", 1'b0, 3, 32'd11, 1'b0);
        run_md("b2b_div", 1'b1, 5, 32'd22, 1'b1);
        run_md("b2b_min", 1'b0, 1, 32'd33, 1'b0);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_timeout();
        int st;
        logic [31:0] r;
        r = $urandom();
        in_valid = 1'b1; in_insn = {5'd0, r[26:7], 5'd7, 2'b00}; md_ready = 1'b0;
        #1;
        st = 0;
        for (int i = 0; i < 60; i++) begin
            if (stall !== 1'b1) break;
            st++;
            @(posedge clock);
            #1;
        end
`ifdef MD_TIMEOUT_EN
        checks++;
        if (st !== MDMAX) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d stall cycles, want %0d", st, MDMAX);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({out_valid, out_exc, out_result, out_rd} !== {2'b11, 32'd0, r[26:22]}) begin
            errors++;
            $display("FAIL timeout_xm: got v=%b e=%b r=%h rd=%0d, want v=1 e=1 r=0 rd=%0d",
                     out_valid, out_exc, out_result, out_rd, r[26:22]);
        end
        in_valid = 1'b0;
`else
        checks++;
        if (st !== 60) begin
            errors++;
            $display("FAIL no_timeout: got %0d stall cycles, want 60", st);
        end
        test_reset();
`endif
    endtask

    task automatic test_reset_busy();
        in_valid = 1'b1; in_insn = {5'd0, 5'd9, 15'd0, 5'd6, 2'b00}; md_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({stall, out_valid, md_start_mult, md_start_div} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_busy: got st=%b v=%b m=%b d=%b, want 0", stall, out_valid, md_start_mult, md_start_div);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1; in_valid = 1'b0; md_ready = 1'b1; md_result = 32'd99;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if ({out_valid, stall} !== 2'b00) begin
                errors++;
                $display("FAIL late_ready: got v=%b st=%b, want 0 0", out_valid, stall);
            end
        end
        md_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_single();
        test_multdiv();
        test_back_to_back();
        test_timeout();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage_pipe.md
EXECUTE_STAGE_PIPE -- requirements
Module: execute_stage_pipe

Interface
REQ-001 Parameter DATA_W, default 32, datapath/PC width (>=32; instruction stays 32 bits).
REQ-002 Parameter MD_MAX_CYCLES, default 40, multdiv timeout limit in cycles.
REQ-003 clock  input  1  single rising-edge clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid / in_insn / in_pc  input  1 / 32 / DATA_W  D/X latch contents.
REQ-006 in_dataA / in_dataB  input  DATA_W  register-file operands rs / rt.
REQ-007 alu_opcode, alu_shamt  output  5, 5  ALU control; alu_opA, alu_opB  output  DATA_W  ALU operands.
REQ-008 alu_result  input  DATA_W; alu_ne, alu_lt  input  1  ALU result and flags.
REQ-009 md_start_mult, md_start_div  output  1  one-cycle start pulses to the multdiv unit.
REQ-010 md_result  input  DATA_W; md_ready, md_exception  input  1  multdiv completion.
REQ-011 stall  output  1  holds upstream stages.
REQ-012 branch_taken  output  1; branch_target  output  DATA_W  redirect.
REQ-013 out_valid, out_exc  output  1; out_result  output  DATA_W; out_rd  output  5  X/M register.

Function
REQ-014 Decode: opcode insn[31:27]; R-type = 00000; ALU op insn[6:2]; shamt insn[11:7]; rd insn[26:22]; imm insn[16:0] sign-extended to DATA_W; J target insn[26:0] zero-extended.
REQ-015 R-type: alu_opcode/shamt from insn, alu_opA=in_dataA, alu_opB=in_dataB.
REQ-016 addi(00101), lw(01000), sw(00111): alu_opcode=00000, alu_shamt=0, opB=imm.
REQ-017 bne(00010), blt(00110): alu_opcode=00001, opA=in_dataA, opB=in_dataB.
REQ-018 jal(00011): alu_opA=in_pc, alu_opB=0; out_rd=31, out_result=in_pc+1.
REQ-019 branch_taken (combinational) = in_valid & !stall & (j(00001) | jal | jr(00100) | bne&alu_ne | blt&alu_lt).
REQ-020 branch_target: j/jal = J target; jr = in_dataA; bne/blt = in_pc+1+imm (mod 2^DATA_W).
REQ-021 R-type ALU op 00110 = mult, 00111 = div; all others single-cycle.
REQ-022 FSM states IDLE, BUSY; reset to IDLE.
REQ-023 IDLE, in_valid & mult/div: pulse md_start_mult or md_start_div for exactly that cycle, stall=1, counter<=0, next BUSY; X/M not loaded.
REQ-024 BUSY: stall=1, md_start_* low, counter increments each cycle; md_ready=1 -> X/M loads out_result=md_result, out_rd=rd, out_exc=md_exception, out_valid=1; stall=0 in that same cycle; next IDLE.
REQ-025 md_ready is ignored in IDLE; a new mult/div in the cycle after completion restarts normally.
REQ-026 Single-cycle path: on each edge with stall=0 and not entering BUSY, X/M loads out_valid=in_valid, out_result=alu_result (jal per REQ-018), out_rd=rd, out_exc=0.
REQ-027 Instructions sw, bne, blt, j, jr load out_rd=0.
REQ-028 in_valid=0 in IDLE: no start, stall=0, out_valid<=0.

Reset
REQ-029 reset_n=0 asynchronously forces IDLE, counter=0, out_valid=0, out_exc=0, out_result=0, out_rd=0.
REQ-030 Reset during BUSY abandons the operation; md_start_* and stall are 0 while reset_n=0; a late md_ready after release is ignored.

Configuration
REQ-031 Macro MD_TIMEOUT_EN defined: in BUSY, when counter reaches MD_MAX_CYCLES-1 without md_ready, X/M loads out_valid=1, out_exc=1, out_result=0, out_rd=rd, FSM returns IDLE, stall=0 that cycle.
REQ-032 MD_TIMEOUT_EN undefined: no timeout; BUSY persists until md_ready or reset; counter logic may be omitted.

Verification
REQ-033 add r3,r1,r2 with alu_result=7 -> next edge out_valid=1, out_result=7, out_rd=3, stall=0.
REQ-034 bne, in_pc=100, imm=-4, alu_ne=1 -> branch_taken=1, branch_target=97; alu_ne=0 -> branch_taken=0.
REQ-035 jal target 0x123, in_pc=50 -> branch_target=0x123, next edge out_rd=31, out_result=51.
REQ-036 mult issued, md_ready after 17 cycles with md_result=42 -> one md_start_mult pulse, stall high 17 cycles, then out_result=42, out_valid=1, stall=0.
REQ-037 div, md_ready never (MD_TIMEOUT_EN, MD_MAX_CYCLES=40) -> out_exc=1, out_result=0 at cycle 40, stall drops; without macro stall stays high.
REQ-038 reset_n low mid-BUSY -> immediate IDLE, stall=0, out_valid=0; stray md_ready afterwards produces no out_valid.
